// File: rtl/tdoa_capture.sv
// tdoa_capture: first-arrival detection and per-channel arrival timestamping
// for the hydrophone front end. Emits one TDOA vector per ping through a
// valid/ready handshake, then applies an echo-rejection hold-off period.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   IDLE       | disarmed; rising edges ignored
//   WAIT_FIRST | armed; waiting for the first rising edge on any channel
//   CAPTURE    | window open; timestamping the remaining channels
//   OUTPUT     | result held on the outputs until valid_o & ready_i
//   HOLD       | post-ping dead time; edges counted as drops
module tdoa_capture #(
    parameter int N       = 4,
    parameter int CNT_W   = 16,
    parameter int WINDOW  = 4096,
    parameter int HOLDOFF = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [N-1:0]       det,
    output logic [N*CNT_W-1:0] tdoa_o,
    output logic [N-1:0]       mask_o,
    output logic               timeout_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               busy_o,
    output logic [7:0]         drop_cnt_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_OUTPUT  = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    localparam int              HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0] LAST_K   = CNT_W'(WINDOW - 1);
    localparam logic [HW-1:0]    HOLD_LOAD = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    logic [2:0]         state_q, state_d;
    logic [N-1:0]       det_q;
    logic [N-1:0]       rise;
    logic [N-1:0]       new_hit;
    logic [N-1:0]       mask_all;
    logic [N-1:0]       mask_q, mask_d;
    logic [N*CNT_W-1:0] ts_q, ts_d;
    logic [CNT_W-1:0]   d_q, d_d;
    logic               timeout_q, timeout_d;
    logic               valid_q, valid_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [7:0]         drop_q, drop_d;

    assign rise = det & ~det_q;

    // Next-state and datapath decisions for the ping sequencer.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ts_d      = ts_q;
        d_d       = d_q;
        timeout_d = timeout_q;
        valid_d   = valid_q;
        hold_d    = hold_q;
        drop_d    = drop_q;
        new_hit   = '0;
        mask_all  = '0;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (|rise) begin
                    // The first arrival resets the whole result; the delay
                    // counter then reads k during cycle t0+k.
                    mask_d    = rise;
                    ts_d      = '0;
                    timeout_d = 1'b0;
                    d_d       = CNT_W'(1);
                    if (&rise) begin
                        state_d = S_OUTPUT;
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    mask_d  = '0;
                end else begin
                    new_hit  = rise & ~mask_q;
                    mask_all = mask_q | new_hit;
                    mask_d   = mask_all;
                    for (int i = 0; i < N; i++) begin
                        if (new_hit[i]) ts_d[i*CNT_W +: CNT_W] = d_q;
                    end
                    d_d = d_q + CNT_W'(1);
                    if (&mask_all) begin
                        state_d   = S_OUTPUT;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                    end else if (d_q == LAST_K) begin
                        state_d   = S_OUTPUT;
                        valid_d   = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
            end
            S_OUTPUT: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    if (HOLDOFF > 0) begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_LOAD;
                    end else if (enable) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    state_d = enable ? S_WAIT : S_IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // One drop per cycle with any edge, not per channel.
        if ((state_q == S_OUTPUT || state_q == S_HOLD) && (|rise) && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;
    end

    // Edge-detect history, tracked in every state so held lines never re-trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) det_q <= '0;
        else        det_q <= det;
    end

    // Sequencer state, result registers and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            ts_q      <= '0;
            d_q       <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
            hold_q    <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            ts_q      <= ts_d;
            d_q       <= d_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
            hold_q    <= hold_d;
            drop_q    <= drop_d;
        end
    end

    assign tdoa_o     = ts_q;
    assign mask_o     = mask_q;
    assign timeout_o  = timeout_q;
    assign valid_o    = valid_q;
    assign busy_o     = (state_q != S_IDLE);
    assign drop_cnt_o = drop_q;

endmodule
